// File: rtl/siso_shift_ctrl_pkg.sv
// Shared types and constants for the serial-in/serial-out shift controller.
package siso_shift_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One extra bit so the counter can represent WIDTH itself without aliasing.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/siso_shift_ctrl_sreg.sv
// Loadable left-shift register; load wins over shift when both are asserted.
module shift_reg_ctrlable #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             si,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load)
      sr_d = par_in;
    else if (shift_en)
      sr_d = {sr_q[WIDTH-2:0], si};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sr_q <= '0;
    else
      sr_q <= sr_d;
  end

  assign par_out = sr_q;
  assign msb     = sr_q[WIDTH-1];

endmodule

// File: rtl/siso_shift_ctrl.sv
// Transfer controller: serializes din MSB-first on so while capturing si into dout.
module siso_shift_ctrl
  import siso_shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             hold,
  input  logic             si,
  output logic             ready,
  output logic             busy,
  output logic             so,
  output logic             so_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  localparam int              CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             load, shift_en;
  logic [WIDTH-1:0] par_out;
  logic             sr_msb;
  logic             unused_par_msb;

  shift_reg_ctrlable #(.WIDTH(WIDTH)) u_sreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .si       (si),
    .par_in   (din),
    .par_out  (par_out),
    .msb      (sr_msb)
  );

  // The outgoing MSB leaves through so, so only the lower bits feed dout.
  assign unused_par_msb = par_out[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          shift_en = 1'b1;
          if (cnt_q == LAST) begin
            dout_d  = {par_out[WIDTH-2:0], si};
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q == SHIFT) || (state_q == DONE);
  assign so         = (state_q == SHIFT) ? sr_msb : 1'b0;
  assign so_valid   = (state_q == SHIFT) && !hold;
  assign dout       = dout_q;
  assign dout_valid = (state_q == DONE);

endmodule
